// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared types and constants for the serial program loader.
//   state_e      - loader FSM states
//   ERR_*        - values reported on ERR_CODE
//   PROG_AW/DW   - program memory address / instruction widths
package prog_loader_pkg;

  localparam int PROG_AW = 10;
  localparam int PROG_DW = 18;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_B0,
    S_B1,
    S_B2,
    S_WRITE,
    S_CHK
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_CSUM    = 2'b01;
  localparam logic [1:0] ERR_FMT     = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

endpackage

// File: rtl/prog_loader_timer.sv
// prog_loader_timer: inactivity counter for the loader.
//   PROG_CLK - clock, rising edge
//   RST_N    - asynchronous active-low reset
//   clr      - restart the count (a byte was accepted)
//   en       - count this cycle
//   expired  - TIMEOUT_CYCLES counted cycles have elapsed since the last clear
module prog_loader_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic PROG_CLK,
  input  logic RST_N,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [31:0] cnt_q;

  // expired is flagged while the count sits one below the limit so the
  // timeout takes effect on the TIMEOUT_CYCLES-th counted edge.
  assign expired = en && (cnt_q >= (TIMEOUT_CYCLES - 32'd1));

  always_ff @(posedge PROG_CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && !expired) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// prog_loader: framed byte stream -> 18-bit instruction writes.
// Frame: SYNC, LEN_LO, LEN_HI, N x (B0, B1, B2), CHK; N = LEN[9:0] + 1.
//   PROG_CLK, RST_N         - clock / asynchronous active-low reset
//   RX_DATA/RX_VALID/RX_READY - byte input handshake
//   PROG_WE/WADDR/WDATA     - program memory write port (one-cycle strobe)
//   CPU_HOLD                - MCU held in reset while a load is in progress
//   LOAD_DONE/LOAD_ERR      - sticky result of the last frame
//   ERR_CODE                - reason for the last abort
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter logic [7:0]         SYNC_BYTE      = 8'hA5,
  parameter logic [PROG_AW-1:0] BASE_ADDR      = '0,
  parameter int unsigned        TIMEOUT_CYCLES = 1_000_000
) (
  input  logic               PROG_CLK,
  input  logic               RST_N,
  input  logic [7:0]         RX_DATA,
  input  logic               RX_VALID,
  output logic               RX_READY,
  output logic               PROG_WE,
  output logic [PROG_AW-1:0] PROG_WADDR,
  output logic [PROG_DW-1:0] PROG_WDATA,
  output logic               CPU_HOLD,
  output logic               LOAD_DONE,
  output logic               LOAD_ERR,
  output logic [1:0]         ERR_CODE
);

  state_e       state_q, state_d;
  logic         alive_q;
  logic [7:0]   sum_q;
  logic [9:0]   cnt_q;
  logic [7:0]   b0_q, b1_q;
  logic         acc, hi_bad, fmt_err, csum_err, tmo_exp, tmo_err;

  assign acc      = RX_VALID && RX_READY;
  assign hi_bad   = (RX_DATA[7:2] != 6'd0);
  assign fmt_err  = acc && hi_bad && ((state_q == S_LEN_HI) || (state_q == S_B2));
  assign csum_err = acc && (state_q == S_CHK) && (RX_DATA != sum_q);
  // A byte arriving in the expiry cycle wins over the timeout.
  assign tmo_err  = tmo_exp && !acc;

  prog_loader_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .PROG_CLK(PROG_CLK),
    .RST_N   (RST_N),
    .clr     (acc),
    .en      ((state_q != S_IDLE) && (state_q != S_WRITE)),
    .expired (tmo_exp)
  );

  // State register
  always_ff @(posedge PROG_CLK or negedge RST_N) begin
    if (!RST_N) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (acc && (RX_DATA == SYNC_BYTE)) state_d = S_LEN_LO;
      S_LEN_LO: if (acc) state_d = S_LEN_HI;
      S_LEN_HI: if (acc) state_d = hi_bad ? S_IDLE : S_B0;
      S_B0:     if (acc) state_d = S_B1;
      S_B1:     if (acc) state_d = S_B2;
      S_B2:     if (acc) state_d = hi_bad ? S_IDLE : S_WRITE;
      S_WRITE:  state_d = (cnt_q == 10'd0) ? S_CHK : S_B0;
      S_CHK:    if (acc) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (tmo_err) state_d = S_IDLE;
  end

  // Outputs: the write cycle is the only stall; alive_q keeps RX_READY low
  // while reset is held.
  always_comb begin
    RX_READY = 1'b0;
    PROG_WE  = 1'b0;
    if (state_q == S_WRITE) PROG_WE  = 1'b1;
    else                    RX_READY = alive_q;
  end

  // Datapath and status flags
  always_ff @(posedge PROG_CLK or negedge RST_N) begin
    if (!RST_N) begin
      alive_q    <= 1'b0;
      sum_q      <= '0;
      cnt_q      <= '0;
      b0_q       <= '0;
      b1_q       <= '0;
      PROG_WADDR <= '0;
      PROG_WDATA <= '0;
      CPU_HOLD   <= 1'b0;
      LOAD_DONE  <= 1'b0;
      LOAD_ERR   <= 1'b0;
      ERR_CODE   <= ERR_NONE;
    end else begin
      alive_q <= 1'b1;
      unique case (state_q)
        S_IDLE: if (acc && (RX_DATA == SYNC_BYTE)) begin
          CPU_HOLD   <= 1'b1;
          LOAD_DONE  <= 1'b0;
          LOAD_ERR   <= 1'b0;
          ERR_CODE   <= ERR_NONE;
          sum_q      <= '0;
          PROG_WADDR <= BASE_ADDR;
        end
        S_LEN_LO: if (acc) begin
          sum_q      <= sum_q + RX_DATA;
          cnt_q[7:0] <= RX_DATA;
        end
        S_LEN_HI: if (acc) begin
          sum_q      <= sum_q + RX_DATA;
          cnt_q[9:8] <= RX_DATA[1:0];
        end
        S_B0: if (acc) begin
          sum_q <= sum_q + RX_DATA;
          b0_q  <= RX_DATA;
        end
        S_B1: if (acc) begin
          sum_q <= sum_q + RX_DATA;
          b1_q  <= RX_DATA;
        end
        S_B2: if (acc) begin
          sum_q      <= sum_q + RX_DATA;
          PROG_WDATA <= {RX_DATA[1:0], b1_q, b0_q};
        end
        // cnt_q holds words remaining minus one; address wraps naturally.
        S_WRITE: begin
          PROG_WADDR <= PROG_WADDR + 10'd1;
          if (cnt_q != 10'd0) cnt_q <= cnt_q - 10'd1;
        end
        S_CHK: if (acc && !csum_err) begin
          LOAD_DONE <= 1'b1;
          CPU_HOLD  <= 1'b0;
        end
        default: ;
      endcase
      // Aborts leave CPU_HOLD set: memory may be partially written.
      if (fmt_err) begin
        LOAD_ERR <= 1'b1;
        ERR_CODE <= ERR_FMT;
      end else if (csum_err) begin
        LOAD_ERR <= 1'b1;
        ERR_CODE <= ERR_CSUM;
      end else if (tmo_err) begin
        LOAD_ERR <= 1'b1;
        ERR_CODE <= ERR_TIMEOUT;
      end
    end
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Serial program loader: the write-side counterpart of the program ROM.
- Accepts a framed byte stream (from UART RX or a debug bridge) over a valid/ready handshake and assembles 18-bit instructions.
- Writes each instruction into the 1024x18 program memory through a synchronous write port.
- Holds the MCU in reset (CPU_HOLD) while a load is in progress.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- BASE_ADDR, 10'd0, program address of the first written word.
- TIMEOUT_CYCLES, 1_000_000, maximum clocks between accepted bytes inside a frame; 32-bit counter.

Ports:
- PROG_CLK  in  1  system clock, all logic on rising edge.
- RST_N  in  1  asynchronous active-low reset.
- RX_DATA  in  8  incoming byte.
- RX_VALID  in  1  RX_DATA valid.
- RX_READY  out  1  loader accepts byte; transfer occurs when RX_VALID and RX_READY are both high on a clock edge.
- PROG_WE  out  1  one-cycle program-memory write strobe.
- PROG_WADDR  out  10  write address.
- PROG_WDATA  out  18  write data (instruction).
- CPU_HOLD  out  1  high = MCU held in reset.
- LOAD_DONE  out  1  sticky: last frame completed with good checksum.
- LOAD_ERR  out  1  sticky: last frame aborted.
- ERR_CODE  out  2  00 none, 01 checksum, 10 format, 11 timeout.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. RST_N low forces all outputs to 0 (RX_READY=0, PROG_WE=0, PROG_WADDR=0, PROG_WDATA=0, CPU_HOLD=0, LOAD_DONE=0, LOAD_ERR=0, ERR_CODE=00), FSM to IDLE, sum and timer to 0. First cycle after release: RX_READY=1.
- Frame format: SYNC, LEN_LO, LEN_HI, N x (B0, B1, B2), CHK.
  - N = {LEN_HI[1:0], LEN_LO} + 1, giving 1..1024 words.
  - Word = {B2[1:0], B1, B0}.
  - CHK = 8-bit modular sum of LEN_LO, LEN_HI and all data bytes.
- States: IDLE, LEN_LO, LEN_HI, B0, B1, B2, WRITE, CHK.
  - IDLE: accepted bytes other than SYNC_BYTE are discarded. Accepting SYNC_BYTE: CPU_HOLD<=1, LOAD_DONE<=0, LOAD_ERR<=0, ERR_CODE<=00, sum<=0, addr<=BASE_ADDR, go to LEN_LO.
  - LEN_LO -> LEN_HI. LEN_HI[7:2] != 0 -> format error; otherwise go to B0.
  - B0 -> B1 -> B2. B2[7:2] != 0 -> format error; otherwise go to WRITE.
  - WRITE (exactly 1 cycle): RX_READY=0, PROG_WE=1 with registered PROG_WADDR/PROG_WDATA. Address increments after the write and wraps 1023->0. Remaining count decrements; if 0 go to CHK, else go to B0.
  - Write latency: PROG_WE asserts the cycle after the B2 handshake.
  - CHK: received byte == sum -> LOAD_DONE<=1, CPU_HOLD<=0, go to IDLE. Mismatch -> checksum error.
- Error (any state): LOAD_ERR<=1, ERR_CODE set, CPU_HOLD stays 1 (memory is partially written), go to IDLE. Only a successful frame or reset clears CPU_HOLD.
- Timer: counts cycles in every non-IDLE state except WRITE and clears on each accepted byte. Reaching TIMEOUT_CYCLES raises a timeout error in that cycle.
- RX_READY is 1 in every state except WRITE; no byte is lost across the WRITE stall.
- PROG_WE is never high outside WRITE.
- Reset mid-frame: abort immediately, no further writes; memory contents already written are unchanged.

Decomposition:
- Package prog_loader_pkg:
  - state enum.
  - ERR_NONE/ERR_CSUM/ERR_FMT/ERR_TIMEOUT constants.
  - PROG_AW=10, PROG_DW=18.
- Sub-module prog_loader_timer: resettable inactivity counter with clear/enable inputs and an expired output. Everything else stays in one FSM module.

Test Plan:
- Good 2-word frame. Bytes A5,01,00,34,12,02,78,56,01,18 -> PROG_WE pulses at addr 0 data 0x21234 and addr 1 data 0x15678. After CHK: LOAD_DONE=1, CPU_HOLD=0, ERR_CODE=00.
- Same frame with CHK=19 -> no extra writes beyond the 2 words; LOAD_ERR=1, ERR_CODE=01, CPU_HOLD=1. A following good frame clears LOAD_ERR and drops CPU_HOLD.
- Format errors. B2=0x04 in the first word -> ERR_CODE=10 with no PROG_WE. LEN_HI=0x04 -> ERR_CODE=10 before any data byte.
- Timeout with TIMEOUT_CYCLES=100. Send A5,00,00,11 then idle -> LOAD_ERR=1, ERR_CODE=11 exactly 100 cycles after the last handshake, no write. Bytes 00,FF before A5 are ignored.
- Full frame with LEN=0x3FF and BASE_ADDR=10'd1 -> 1024 writes with addresses 1..1023 then 0, correct checksum, LOAD_DONE=1. RX_VALID held high throughout proves RX_READY drops only in WRITE cycles.
- Assert RST_N low during the B1 of word 5 -> all outputs 0 asynchronously, PROG_WE never pulses again. After release, a new A5 frame loads correctly.
